// File: rtl/seq_scan_if.sv
// Load/result handshake bundle between a word source and the 1101 scan controller.
interface seq_scan_if #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned CNT_BITS  = 4
);
    logic                 load_valid;
    logic                 load_ready;
    logic [WORD_BITS-1:0] load_data;
    logic                 busy;
    logic                 done;
    logic [CNT_BITS-1:0]  match_count;
    logic                 any_match;

    modport master (
        output load_valid, load_data,
        input  load_ready, busy, done, match_count, any_match
    );

    modport slave (
        input  load_valid, load_data,
        output load_ready, busy, done, match_count, any_match
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Streams an accepted word MSB-first into a serial Moore "1101" detector and
// counts its match pulses, returning a saturating count with a one-cycle done.
module seq_scan_ctrl #(
    parameter int unsigned WORD_BITS = 8,
    parameter int unsigned CNT_BITS  = 4
) (
    input  logic       clk,
    input  logic       rst,
    seq_scan_if.slave  bus,
    output logic       det_n_rst,
    output logic       det_i,
    input  logic       det_o
);
    localparam int unsigned IDX_W = $clog2(WORD_BITS);
    localparam logic [CNT_BITS-1:0]  CNT_MAX  = '1;
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t               state_q;
    logic [WORD_BITS-1:0] shreg_q;
    logic [IDX_W-1:0]     bit_idx_q;
    logic [CNT_BITS-1:0]  cnt_q;
    logic [CNT_BITS-1:0]  cnt_d;
    logic                 load_ready_q;
    logic                 det_n_rst_q;
    logic                 det_i_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 any_match_q;
    logic                 count_en_c;

    // Detector output is only meaningful while bits are in flight (SHIFT/DRAIN).
    always_comb begin
        count_en_c = ((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) && det_o;
        cnt_d      = cnt_q;
        if (count_en_c && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            cnt_q        <= '0;
            load_ready_q <= 1'b1;
            det_n_rst_q  <= 1'b1;
            det_i_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            any_match_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            cnt_q       <= cnt_d;
            any_match_q <= (cnt_d != '0);
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.load_valid && load_ready_q) begin
                        shreg_q      <= bus.load_data;
                        bit_idx_q    <= '0;
                        cnt_q        <= '0;
                        any_match_q  <= 1'b0;
                        load_ready_q <= 1'b0;
                        det_n_rst_q  <= 1'b0;
                        det_i_q      <= 1'b0;
                        busy_q       <= 1'b1;
                        state_q      <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    det_n_rst_q <= 1'b1;
                    det_i_q     <= shreg_q[WORD_BITS-1];
                    state_q     <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    // det_i is pre-loaded with the next MSB so it tracks shreg[MSB] each cycle.
                    shreg_q   <= shreg_q << 1;
                    bit_idx_q <= bit_idx_q + IDX_W'(1);
                    if (bit_idx_q == LAST_IDX) begin
                        det_i_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        det_i_q <= shreg_q[WORD_BITS-2];
                    end
                end
                ST_DRAIN: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    load_ready_q <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready  = load_ready_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.match_count = cnt_q;
    assign bus.any_match   = any_match_q;
    assign det_n_rst       = det_n_rst_q;
    assign det_i           = det_i_q;
endmodule
